// File: rtl/store_unit_pkg.sv
// Shared core definitions for the store path: func3 store encodings,
// FSM state encoding and a legality helper for the store func3 field.
package store_unit_pkg;

    localparam logic [2:0] FUNC3_SB = 3'd0;
    localparam logic [2:0] FUNC3_SH = 3'd1;
    localparam logic [2:0] FUNC3_SW = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } st_state_t;

    function automatic logic func3_legal(input logic [2:0] func3);
        return (func3 == FUNC3_SB) || (func3 == FUNC3_SH) || (func3 == FUNC3_SW);
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Store request / memory write bus bundle.
//   st_*  : request side (valid/ready handshake, addr, data, func3, done/err pulses)
//   mem_* : memory write side (req, word addr, wdata, byte enables, ack)
// slave  : the store unit's view; master : the requester/memory environment.
interface store_unit_if #(parameter int W_SIZE = 32);
    logic              st_valid;
    logic              st_ready;
    logic [15:0]       st_addr;
    logic [W_SIZE-1:0] st_data;
    logic [2:0]        st_func3;
    logic              st_done;
    logic              st_err;
    logic              mem_req;
    logic [15:0]       mem_addr;
    logic [W_SIZE-1:0] mem_wdata;
    logic [3:0]        mem_we;
    logic              mem_ack;

    modport slave (
        input  st_valid, st_addr, st_data, st_func3, mem_ack,
        output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output st_valid, st_addr, st_data, st_func3, mem_ack,
        input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/store_unit_align.sv
// store_align: combinational byte-lane alignment for a store.
//   off    : byte offset within the word (addr[1:0])
//   func3  : store type (SB/SH/SW); any other value yields an empty mask
//   data   : LSB-aligned store data
//   mask8  : byte enables across two consecutive words (low nibble = first word)
//   data64 : data shifted into its byte lanes across the same two words
module store_align
    import store_unit_pkg::*;
#(
    parameter int W_SIZE = 32
) (
    input  logic [1:0]          off,
    input  logic [2:0]          func3,
    input  logic [W_SIZE-1:0]   data,
    output logic [7:0]          mask8,
    output logic [2*W_SIZE-1:0] data64
);
    logic [7:0] base;

    always_comb begin
        base = 8'b0000_0000;
        case (func3)
            FUNC3_SB: base = 8'b0000_0001;
            FUNC3_SH: base = 8'b0000_0011;
            FUNC3_SW: base = 8'b0000_1111;
            default:  base = 8'b0000_0000;
        endcase
    end

    assign mask8  = base << off;
    assign data64 = {{W_SIZE{1'b0}}, data} << {off, 3'b000};
endmodule

// File: rtl/store_unit.sv
// store_unit: accepts one store request at a time and writes it to a
// word-addressed memory as one beat (fits in a word) or two beats
// (straddles a word boundary).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : store_unit_if.slave (request handshake + memory write port)
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | ready for a request; memory port driven to zero
// ST_BEAT0 | writing the word holding the first byte, wait mem_ack
// ST_BEAT1 | writing the following word (split store), wait mem_ack
module store_unit
    import store_unit_pkg::*;
#(
    parameter int W_SIZE = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    store_unit_if.slave  bus
);
    st_state_t           state, state_nxt;
    logic [15:0]         addr_q;
    logic [W_SIZE-1:0]   data_q;
    logic [2:0]          func3_q;
    logic                done_q, err_q;

    logic                accept, finish, legal;
    logic [7:0]          mask8;
    logic [2*W_SIZE-1:0] data64;
    logic [15:0]         word_addr;

    store_align #(.W_SIZE(W_SIZE)) u_align (
        .off    (addr_q[1:0]),
        .func3  (func3_q),
        .data   (data_q),
        .mask8  (mask8),
        .data64 (data64)
    );

    assign word_addr = {addr_q[15:2], 2'b00};
    assign legal     = func3_legal(bus.st_func3);

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        finish        = 1'b0;
        bus.st_ready  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_we    = 4'b0000;
        bus.mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                bus.st_ready = 1'b1;
                if (bus.st_valid) begin
                    accept = 1'b1;
                    // Illegal func3 is consumed here and answered with err+done.
                    if (legal) state_nxt = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = word_addr;
                bus.mem_we    = mask8[3:0];
                bus.mem_wdata = data64[W_SIZE-1:0];
                if (bus.mem_ack) begin
                    if (|mask8[7:4]) begin
                        state_nxt = ST_BEAT1;
                    end else begin
                        state_nxt = ST_IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            ST_BEAT1: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = word_addr + 16'd4;
                bus.mem_we    = mask8[7:4];
                bus.mem_wdata = data64[2*W_SIZE-1:W_SIZE];
                if (bus.mem_ack) begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= 16'h0000;
            data_q  <= '0;
            func3_q <= 3'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= finish | (accept & ~legal);
            err_q  <= accept & ~legal;
            if (accept) begin
                addr_q  <= bus.st_addr;
                data_q  <= bus.st_data;
                func3_q <= bus.st_func3;
            end
        end
    end

    assign bus.st_done = done_q;
    assign bus.st_err  = err_q;
endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;
    import store_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   miss_cnt;

    store_unit_if #(.W_SIZE(32)) bus ();

    store_unit #(.W_SIZE(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations of one store, gathered cycle by cycle (cycle 0 = request cycle).
    int          obs_nb;
    logic [15:0] obs_addr  [0:1];
    logic [3:0]  obs_we    [0:1];
    logic [31:0] obs_wdata [0:1];
    int          obs_done_cyc, obs_done_cnt, obs_err_cyc, obs_err_cnt;
    logic        obs_ready0;

    task automatic run_store(input logic [2:0] f3, input logic [15:0] a, input logic [31:0] d);
        obs_nb = 0; obs_done_cyc = -1; obs_done_cnt = 0; obs_err_cyc = -1; obs_err_cnt = 0;
        @(negedge clk);
        bus.st_valid = 1'b1; bus.st_func3 = f3; bus.st_addr = a; bus.st_data = d;
        obs_ready0 = bus.st_ready;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) bus.st_valid = 1'b0;
            if (bus.mem_req) begin
                if (obs_nb < 2) begin
                    obs_addr[obs_nb] = bus.mem_addr;
                    obs_we[obs_nb] = bus.mem_we;
                    obs_wdata[obs_nb] = bus.mem_wdata;
                end
                obs_nb++;
            end
            if (bus.st_done) begin obs_done_cnt++; if (obs_done_cyc < 0) obs_done_cyc = n; end
            if (bus.st_err) begin obs_err_cnt++; if (obs_err_cyc < 0) obs_err_cyc = n; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vec_cnt++;
        if ({bus.mem_req, bus.mem_we, bus.st_done, bus.st_err} !== 7'b0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: req/we/done/err=%b expected 0000000",
                     {bus.mem_req, bus.mem_we, bus.st_done, bus.st_err});
        end
        vec_cnt++;
        if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 32'h0) begin
            miss_cnt++;
            $display("FAIL reset_bus: addr=%h wdata=%h expected 0000/00000000", bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.st_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL reset_ready: st_ready=%b expected 1", bus.st_ready);
        end
    endtask

    task automatic test_sw_aligned();
        run_store(FUNC3_SW, 16'h0010, 32'hDEADBEEF);
        vec_cnt++;
        if (obs_ready0 !== 1'b1 || obs_nb !== 1) begin
            miss_cnt++;
            $display("FAIL sw_aligned_beats: ready0=%b beats=%0d expected 1/1", obs_ready0, obs_nb);
        end
        vec_cnt++;
        if (obs_addr[0] !== 16'h0010 || obs_we[0] !== 4'b1111 || obs_wdata[0] !== 32'hDEADBEEF) begin
            miss_cnt++;
            $display("FAIL sw_aligned_beat0: addr=%h we=%b wdata=%h expected 0010/1111/deadbeef",
                     obs_addr[0], obs_we[0], obs_wdata[0]);
        end
        vec_cnt++;
        if (obs_done_cyc !== 2 || obs_done_cnt !== 1 || obs_err_cnt !== 0) begin
            miss_cnt++;
            $display("FAIL sw_aligned_done: cyc=%0d cnt=%0d errs=%0d expected 2/1/0",
                     obs_done_cyc, obs_done_cnt, obs_err_cnt);
        end
    endtask

    task automatic test_sb_offset3();
        run_store(FUNC3_SB, 16'h0013, 32'h000000A5);
        vec_cnt++;
        if (obs_nb !== 1 || obs_addr[0] !== 16'h0010 || obs_we[0] !== 4'b1000 || obs_wdata[0] !== 32'hA5000000) begin
            miss_cnt++;
            $display("FAIL sb_off3: beats=%0d addr=%h we=%b wdata=%h expected 1/0010/1000/a5000000",
                     obs_nb, obs_addr[0], obs_we[0], obs_wdata[0]);
        end
        vec_cnt++;
        if (obs_done_cyc !== 2 || obs_done_cnt !== 1) begin
            miss_cnt++;
            $display("FAIL sb_off3_done: cyc=%0d cnt=%0d expected 2/1", obs_done_cyc, obs_done_cnt);
        end
    endtask

    task automatic test_sw_split();
        run_store(FUNC3_SW, 16'h0006, 32'h11223344);
        vec_cnt++;
        if (obs_nb !== 2 || obs_addr[0] !== 16'h0004 || obs_we[0] !== 4'b1100 || obs_wdata[0] !== 32'h33440000) begin
            miss_cnt++;
            $display("FAIL sw_split_beat0: beats=%0d addr=%h we=%b wdata=%h expected 2/0004/1100/33440000",
                     obs_nb, obs_addr[0], obs_we[0], obs_wdata[0]);
        end
        vec_cnt++;
        if (obs_addr[1] !== 16'h0008 || obs_we[1] !== 4'b0011 || obs_wdata[1] !== 32'h00001122) begin
            miss_cnt++;
            $display("FAIL sw_split_beat1: addr=%h we=%b wdata=%h expected 0008/0011/00001122",
                     obs_addr[1], obs_we[1], obs_wdata[1]);
        end
        vec_cnt++;
        if (obs_done_cyc !== 3 || obs_done_cnt !== 1) begin
            miss_cnt++;
            $display("FAIL sw_split_done: cyc=%0d cnt=%0d expected 3/1", obs_done_cyc, obs_done_cnt);
        end
    endtask

    task automatic test_sh_wrap();
        run_store(FUNC3_SH, 16'hFFFF, 32'h0000BEEF);
        vec_cnt++;
        if (obs_nb !== 2 || obs_addr[0] !== 16'hFFFC || obs_we[0] !== 4'b1000 || obs_wdata[0] !== 32'hEF000000) begin
            miss_cnt++;
            $display("FAIL sh_wrap_beat0: beats=%0d addr=%h we=%b wdata=%h expected 2/fffc/1000/ef000000",
                     obs_nb, obs_addr[0], obs_we[0], obs_wdata[0]);
        end
        vec_cnt++;
        if (obs_addr[1] !== 16'h0000 || obs_we[1] !== 4'b0001 || obs_wdata[1] !== 32'h000000BE) begin
            miss_cnt++;
            $display("FAIL sh_wrap_beat1: addr=%h we=%b wdata=%h expected 0000/0001/000000be",
                     obs_addr[1], obs_we[1], obs_wdata[1]);
        end
    endtask

    task automatic test_illegal_func3();
        run_store(3'd3, 16'h0020, 32'h12345678);
        vec_cnt++;
        if (obs_nb !== 0) begin
            miss_cnt++;
            $display("FAIL illegal_no_beat: beats=%0d expected 0", obs_nb);
        end
        vec_cnt++;
        if (obs_done_cyc !== 1 || obs_done_cnt !== 1 || obs_err_cyc !== 1 || obs_err_cnt !== 1) begin
            miss_cnt++;
            $display("FAIL illegal_pulses: done cyc/cnt=%0d/%0d err cyc/cnt=%0d/%0d expected 1/1 1/1",
                     obs_done_cyc, obs_done_cnt, obs_err_cyc, obs_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.st_valid = 1'b1; bus.st_func3 = FUNC3_SW; bus.st_addr = 16'h0100; bus.st_data = 32'hCAFEF00D;
        @(negedge clk);
        // In BEAT0: the second request is presented but must be ignored.
        bus.st_addr = 16'h0200; bus.st_data = 32'h0BADF00D;
        vec_cnt++;
        if (bus.st_ready !== 1'b0 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 32'hCAFEF00D) begin
            miss_cnt++;
            $display("FAIL b2b_first: ready=%b addr=%h wdata=%h expected 0/0100/cafef00d",
                     bus.st_ready, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        vec_cnt++;
        if (bus.st_done !== 1'b1 || bus.st_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL b2b_done_ready: done=%b ready=%b expected 1/1", bus.st_done, bus.st_ready);
        end
        @(negedge clk);
        bus.st_valid = 1'b0;
        vec_cnt++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0200 || bus.mem_wdata !== 32'h0BADF00D) begin
            miss_cnt++;
            $display("FAIL b2b_second: req=%b addr=%h wdata=%h expected 1/0200/0badf00d",
                     bus.mem_req, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        vec_cnt++;
        if (bus.st_done !== 1'b1) begin
            miss_cnt++;
            $display("FAIL b2b_second_done: done=%b expected 1", bus.st_done);
        end
    endtask

    task automatic test_reset_midflight();
        int seen_bad;
        seen_bad = 0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.st_valid = 1'b1; bus.st_func3 = FUNC3_SW; bus.st_addr = 16'h0040; bus.st_data = 32'h55AA55AA;
        @(negedge clk);
        bus.st_valid = 1'b0;
        repeat (4) @(negedge clk);
        vec_cnt++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0040 || bus.mem_we !== 4'b1111 || bus.mem_wdata !== 32'h55AA55AA) begin
            miss_cnt++;
            $display("FAIL stall_hold: req=%b addr=%h we=%b wdata=%h expected 1/0040/1111/55aa55aa",
                     bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 4'b0000 || bus.st_done !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reset_abort: req=%b we=%b done=%b expected 0/0000/0",
                     bus.mem_req, bus.mem_we, bus.st_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.st_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL reset_abort_ready: st_ready=%b expected 1", bus.st_ready);
        end
        for (int n = 0; n < 5; n++) begin
            if (bus.mem_req !== 1'b0 || bus.st_done !== 1'b0) seen_bad++;
            @(negedge clk);
        end
        vec_cnt++;
        if (seen_bad !== 0) begin
            miss_cnt++;
            $display("FAIL reset_abort_quiet: cycles with req/done=%0d expected 0", seen_bad);
        end
    endtask

    initial begin
        vec_cnt = 0; miss_cnt = 0;
        bus.st_valid = 1'b0; bus.st_addr = 16'h0; bus.st_data = 32'h0;
        bus.st_func3 = 3'd0; bus.mem_ack = 1'b1;
        test_reset();
        test_sw_aligned();
        test_sb_offset3();
        test_sw_split();
        test_sh_wrap();
        test_illegal_func3();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter W_SIZE, default 32, data word width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; every register is clocked on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports st_valid (input, 1, store request valid) and st_ready (output, 1, unit can accept a request).
REQ-005 SHALL have ports st_addr (input, 16, byte address), st_data (input, W_SIZE, store data, LSB-aligned) and st_func3 (input, 3, store type: SB=0, SH=1, SW=2).
REQ-006 SHALL have ports st_done (output, 1, one-cycle completion pulse) and st_err (output, 1, one-cycle illegal-func3 pulse).
REQ-007 SHALL have ports mem_req (output, 1, write request), mem_addr (output, 16, word address with bits[1:0]=0), mem_wdata (output, W_SIZE, write data) and mem_we (output, 4, byte write enables).
REQ-008 SHALL have port mem_ack (input, 1, memory accepted the current beat).

Function
REQ-009 SHALL implement a three-state FSM: IDLE, BEAT0, BEAT1.
REQ-010 SHALL drive st_ready=1 only in IDLE; a request is accepted when st_valid and st_ready are both 1 at a clock edge.
REQ-011 SHALL capture st_addr, st_data and st_func3 into registers on accept; st_* inputs are ignored outside IDLE.
REQ-012 SHALL compute off=addr[1:0] and base mask SB=0001, SH=0011, SW=1111, giving mask8 = base<<off (8 bits) and data64 = {32'b0,data}<<(8*off).
REQ-013 SHALL, in BEAT0, drive mem_req=1, mem_addr={addr[15:2],2'b00}, mem_we=mask8[3:0] and mem_wdata=data64[31:0].
REQ-014 SHALL, in BEAT1, drive mem_req=1, mem_addr={addr[15:2],2'b00}+4 (16-bit modulo; 0xFFFC+4 wraps to 0x0000), mem_we=mask8[7:4] and mem_wdata=data64[63:32].
REQ-015 SHALL hold mem_req, mem_addr, mem_wdata and mem_we stable until mem_ack=1; mem_ack outside BEAT0/BEAT1 is ignored.
REQ-016 SHALL, on mem_ack in BEAT0, go to BEAT1 if mask8[7:4]!=0, else to IDLE.
REQ-017 SHALL, on mem_ack in BEAT1, go to IDLE.
REQ-018 SHALL pulse st_done for exactly one cycle, registered, in the cycle after the final mem_ack; st_ready is also 1 in that cycle, so back-to-back requests are accepted.
REQ-019 SHALL handle illegal func3 (any value other than 0, 1, 2) as follows: accept it, issue no memory beat, stay in IDLE, and pulse st_err and st_done together in the following cycle.
REQ-020 SHALL give a single store, with mem_ack tied high, a latency of accept-edge → BEAT0 in the next cycle → st_done 2 cycles after accept (aligned) or 3 cycles after accept (split).
REQ-021 SHALL drive mem_req=0, mem_we=0, mem_wdata=0 and mem_addr=0 whenever the FSM is in IDLE.

Reset
REQ-022 SHALL, on rst_n=0 asynchronously, force the FSM to IDLE, mem_req=0, mem_we=0, st_done=0 and st_err=0, and clear all captured registers to 0.
REQ-023 SHALL abandon any in-flight store when reset asserts mid-operation: no further beat is issued and no st_done is produced.
REQ-024 SHALL drive st_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-025 SHALL take the SB/SH/SW func3 constants and the FSM state encodings from the shared core package/header used by the load path.
REQ-026 SHALL place the mask/data generation (REQ-012) in one combinational sub-module, store_align, with inputs off and func3 and outputs mask8 and data64.

Verification
REQ-027 SHALL cover: SW addr=0x0010, data=0xDEADBEEF, mem_ack=1 → one beat, mem_addr=0x0010, mem_we=1111, mem_wdata=0xDEADBEEF, st_done 2 cycles after accept.
REQ-028 SHALL cover: SB addr=0x0013, data=0x000000A5 → one beat, mem_we=1000, mem_wdata=0xA5000000.
REQ-029 SHALL cover: SW addr=0x0006, data=0x11223344 → beat0 mem_addr=0x0004, we=1100, wdata=0x33440000; beat1 mem_addr=0x0008, we=0011, wdata=0x00001122.
REQ-030 SHALL cover: SH addr=0xFFFF, data=0xBEEF → beat0 mem_addr=0xFFFC, we=1000, wdata=0xEF000000; beat1 mem_addr=0x0000, we=0001, wdata=0x000000BE.
REQ-031 SHALL cover: func3=3 → no mem_req; st_err=1 and st_done=1 for exactly one cycle.
REQ-032 SHALL cover: mem_ack held low 5 cycles then rst_n pulsed low in BEAT0 → mem_req drops immediately, no st_done, st_ready=1 after release.
